// File: rtl/mem_result_checker_if.sv
// Bundle between the memory subsystem and the end-of-run checker: DM write snoop, golden load, DM read-back, verdict.
// Latency: n/a (wires only).
// Backpressure: none; the DM read port answers every request exactly one cycle later.
interface mem_result_checker_if #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int GOLDEN_DEPTH = 1024,
    parameter int CYC_W        = 64
);
    localparam int GA_W = $clog2(GOLDEN_DEPTH);
    localparam int GN_W = $clog2(GOLDEN_DEPTH + 1);

    // DM write port (snooped)
    logic                  dm_we;
    logic [ADDR_W-1:0]     dm_addr;
    logic [DATA_W-1:0]     dm_wdata;
    logic [DATA_W/8-1:0]   dm_bstrb;
    // golden memory load
    logic                  gld_we;
    logic [GA_W-1:0]       gld_addr;
    logic [DATA_W-1:0]     gld_wdata;
    logic [GN_W-1:0]       gld_num;
    // DM read-back
    logic                  rd_req;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_W-1:0]     rd_data;
    // verdict
    logic                  done;
    logic                  pass;
    logic                  timeout;
    logic [GN_W-1:0]       err_cnt;
    logic                  mm_valid;
    logic [ADDR_W-1:0]     mm_addr;
    logic [DATA_W-1:0]     mm_data;
    logic [DATA_W-1:0]     mm_exp;
    logic [CYC_W-1:0]      total_cycle;
    logic [DATA_W-1:0]     cyc_lo;
    logic [DATA_W-1:0]     cyc_hi;

    // checker side
    modport slave (
        input  dm_we, dm_addr, dm_wdata, dm_bstrb,
        input  gld_we, gld_addr, gld_wdata, gld_num,
        output rd_req, rd_addr,
        input  rd_data,
        output done, pass, timeout, err_cnt,
        output mm_valid, mm_addr, mm_data, mm_exp,
        output total_cycle, cyc_lo, cyc_hi
    );

    // memory subsystem / bench side
    modport master (
        output dm_we, dm_addr, dm_wdata, dm_bstrb,
        output gld_we, gld_addr, gld_wdata, gld_num,
        input  rd_req, rd_addr,
        output rd_data,
        input  done, pass, timeout, err_cnt,
        input  mm_valid, mm_addr, mm_data, mm_exp,
        input  total_cycle, cyc_lo, cyc_hi
    );
endinterface

// File: rtl/mem_result_checker.sv
// End-of-run checker: detects the software end marker (or a cycle timeout), reads back the result window and compares it to golden.
// Latency: first read 1 cycle after the marker write, done N+2 cycles after it (N+4 with CHECK_RDCYCLE_EN).
// Backpressure: none; one read per cycle, DM must return data exactly one cycle after each request.
// Optional feature macro CHECK_RDCYCLE_EN: two extra reads after the window capture the software cycle words into cyc_lo/cyc_hi.
module mem_result_checker #(
    parameter int                ADDR_W       = 14,
    parameter int                DATA_W       = 32,
    parameter int                GOLDEN_DEPTH = 1024,
    parameter logic [ADDR_W-1:0] END_ADDR     = 'h3fff,
    parameter logic [DATA_W-1:0] END_CODE     = '1,
    parameter logic [ADDR_W-1:0] TEST_START   = 'h2000,
    parameter int                MAX_CYCLE    = 100000,
    parameter int                CYC_W        = 64
) (
    input  logic clk,
    input  logic rst,
    mem_result_checker_if.slave bus
);
    localparam int GA_W  = $clog2(GOLDEN_DEPTH);
    localparam int GN_W  = $clog2(GOLDEN_DEPTH + 1);
    localparam int IDX_W = GN_W + 1;
`ifdef CHECK_RDCYCLE_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    typedef enum logic [1:0] {RUN, READ, FLUSH, FINISH} state_t;
    state_t state, state_nxt;

    logic [DATA_W-1:0] golden [GOLDEN_DEPTH];
    logic [DATA_W-1:0] gld_q;

    logic [DATA_W-1:0] shadow, shadow_nxt;
    logic              marker_hit, timeout_hit;
    logic [GN_W-1:0]   n_now, n_q;
    logic [IDX_W-1:0]  reqs_now, reqs_q, idx;
    logic [CYC_W-1:0]  total_cycle_q;
    logic              timeout_q;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              is_cmp;

    logic              cmp_is;
    logic [ADDR_W-1:0] cmp_addr;
    logic              mismatch;
    logic [GN_W-1:0]   err_cnt_q, err_nxt;

    logic              done_q, pass_q, mm_valid_q;
    logic [ADDR_W-1:0] mm_addr_q;
    logic [DATA_W-1:0] mm_data_q, mm_exp_q;

    // Shadow of the marker word after this cycle's byte-enabled write, so detection sees the updated value.
    always_comb begin
        shadow_nxt = shadow;
        for (int b = 0; b < DATA_W/8; b++) begin
            if (bus.dm_we && (bus.dm_addr == END_ADDR) && bus.dm_bstrb[b])
                shadow_nxt[8*b +: 8] = bus.dm_wdata[8*b +: 8];
        end
    end

    // End conditions and window size; the marker outranks a timeout landing in the same cycle.
    always_comb begin
        marker_hit  = (state == RUN) && (shadow_nxt == END_CODE);
        timeout_hit = (state == RUN) && (MAX_CYCLE != 0) && !marker_hit &&
                      (total_cycle_q == CYC_W'(MAX_CYCLE - 1));
        n_now       = (bus.gld_num > GN_W'(GOLDEN_DEPTH)) ? GN_W'(GOLDEN_DEPTH) : bus.gld_num;
        reqs_now    = {1'b0, n_now} + IDX_W'(EXTRA);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // Next-state logic; an empty read plan skips straight to the flush cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:    if (marker_hit || timeout_hit)
                        state_nxt = (reqs_now == '0) ? FLUSH : READ;
            READ:   if ((idx + IDX_W'(1)) == reqs_q) state_nxt = FLUSH;
            FLUSH:  state_nxt = FINISH;
            FINISH: state_nxt = FINISH;
            default: state_nxt = RUN;
        endcase
    end

    // Read-request outputs: one address per READ cycle, address idle at zero otherwise.
    always_comb begin
        rd_req  = (state == READ);
        rd_addr = rd_req ? (TEST_START + ADDR_W'(idx)) : '0;
        is_cmp  = rd_req && (idx < {1'b0, n_q});
    end

    // Golden loads only while the program runs; contents survive reset.
    always_ff @(posedge clk) begin
        if ((state == RUN) && bus.gld_we) golden[bus.gld_addr] <= bus.gld_wdata;
        if (is_cmp) gld_q <= golden[idx[GA_W-1:0]];
    end

    // Run phase bookkeeping: shadow, cycle counter, and the window size latched when leaving RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow        <= '0;
            total_cycle_q <= '0;
            n_q           <= '0;
            reqs_q        <= '0;
            timeout_q     <= 1'b0;
        end else if (state == RUN) begin
            shadow <= shadow_nxt;
            if (state_nxt == RUN) begin
                total_cycle_q <= total_cycle_q + CYC_W'(1);
            end else begin
                n_q       <= n_now;
                reqs_q    <= reqs_now;
                timeout_q <= timeout_hit;
            end
        end
    end

    assign mismatch = cmp_is && (bus.rd_data !== gld_q);
    assign err_nxt  = err_cnt_q + GN_W'(mismatch);

    // Read index and the one-cycle delayed tag that pairs each response with its request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            cmp_is   <= 1'b0;
            cmp_addr <= '0;
        end else begin
            idx      <= (state == READ) ? idx + IDX_W'(1) : '0;
            cmp_is   <= is_cmp;
            cmp_addr <= rd_addr;
        end
    end

    // Compare, mismatch report and final verdict; a timeout charges every window word as failed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q  <= '0;
            mm_valid_q <= 1'b0;
            mm_addr_q  <= '0;
            mm_data_q  <= '0;
            mm_exp_q   <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            mm_valid_q <= mismatch;
            err_cnt_q  <= err_nxt;
            if (mismatch) begin
                mm_addr_q <= cmp_addr;
                mm_data_q <= bus.rd_data;
                mm_exp_q  <= gld_q;
            end
            if (state == FLUSH) begin
                done_q <= 1'b1;
                pass_q <= !timeout_q && (err_nxt == '0);
                if (timeout_q) err_cnt_q <= n_q;
            end
        end
    end

`ifdef CHECK_RDCYCLE_EN
    logic cap_lo, cap_hi;
    logic [DATA_W-1:0] cyc_lo_q, cyc_hi_q;

    // Capture the two words following the window as the software-recorded cycle count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_lo   <= 1'b0;
            cap_hi   <= 1'b0;
            cyc_lo_q <= '0;
            cyc_hi_q <= '0;
        end else begin
            cap_lo <= rd_req && (idx == {1'b0, n_q});
            cap_hi <= rd_req && (idx == ({1'b0, n_q} + IDX_W'(1)));
            if (cap_lo) cyc_lo_q <= bus.rd_data;
            if (cap_hi) cyc_hi_q <= bus.rd_data;
        end
    end

    assign bus.cyc_lo = cyc_lo_q;
    assign bus.cyc_hi = cyc_hi_q;
`else
    assign bus.cyc_lo = '0;
    assign bus.cyc_hi = '0;
`endif

    assign bus.rd_req      = rd_req;
    assign bus.rd_addr     = rd_addr;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.timeout     = timeout_q;
    assign bus.err_cnt     = err_cnt_q;
    assign bus.mm_valid    = mm_valid_q;
    assign bus.mm_addr     = mm_addr_q;
    assign bus.mm_data     = mm_data_q;
    assign bus.mm_exp      = mm_exp_q;
    assign bus.total_cycle = total_cycle_q;
endmodule

// File: tb/tb_mem_result_checker.sv
// Directed bench for mem_result_checker: marker detection, compare, mismatch report, timeout, empty window, reset mid-read.
// Latency expectations are computed from the marker cycle; extra read count follows CHECK_RDCYCLE_EN.
// Backpressure: DM model answers each request one cycle later.
module tb_mem_result_checker;
`ifdef CHECK_RDCYCLE_EN
    localparam int XR = 2;
`else
    localparam int XR = 0;
`endif

    logic clk;
    logic rst;

    mem_result_checker_if #(.ADDR_W(14), .DATA_W(32), .GOLDEN_DEPTH(1024), .CYC_W(64)) bus ();

    mem_result_checker #(
        .ADDR_W(14), .DATA_W(32), .GOLDEN_DEPTH(1024),
        .END_ADDR(14'h3fff), .END_CODE(32'hffffffff), .TEST_START(14'h2000),
        .MAX_CYCLE(100), .CYC_W(64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DM read model: words at TEST_START+k come from dm_arr[k]
    logic [31:0] dm_arr [0:7];
    always @(posedge clk) begin
        if (bus.rd_req) begin
            if ((bus.rd_addr >= 14'h2000) && (bus.rd_addr < 14'h2008))
                bus.rd_data <= dm_arr[bus.rd_addr - 14'h2000];
            else
                bus.rd_data <= 32'h0;
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mm_cnt = 0;
    int rd_cnt = 0;
    int done_at;
    logic [13:0] mm_a;
    logic [31:0] mm_d;
    logic [31:0] mm_e;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock; sample 1 time unit after the edge and log pulses
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.mm_valid) begin
            mm_cnt++;
            mm_a = bus.mm_addr;
            mm_d = bus.mm_data;
            mm_e = bus.mm_exp;
        end
        if (bus.rd_req) rd_cnt++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0; bus.dm_bstrb = '0;
        bus.gld_we = 1'b0; bus.gld_addr = '0; bus.gld_wdata = '0;
        step();
        step();
        rst = 1'b0;
        cyc = 0; mm_cnt = 0; rd_cnt = 0;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic write_dm(input logic [13:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.dm_we = 1'b1; bus.dm_addr = a; bus.dm_wdata = d; bus.dm_bstrb = s;
        step();
        bus.dm_we = 1'b0; bus.dm_bstrb = '0;
    endtask

    task automatic wait_done(output int at);
        for (int k = 0; k < 40 && !bus.done; k++) step();
        check("done_seen", bus.done, 1);
        at = cyc;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) dm_arr[i] = 32'(i + 1);
        dm_arr[4] = 32'h55; dm_arr[5] = 32'h66;
        bus.gld_num = 11'd4;
        do_reset();

        // reset values
        check("rst_done", bus.done, 0);
        check("rst_pass", bus.pass, 0);
        check("rst_rd_req", bus.rd_req, 0);
        check("rst_rd_addr", bus.rd_addr, 0);
        check("rst_total", bus.total_cycle, 0);
        check("rst_err", bus.err_cnt, 0);

        // scenario 1: clean run, marker at cycle 50
        for (int i = 0; i < 4; i++) begin
            bus.gld_we = 1'b1; bus.gld_addr = 10'(i); bus.gld_wdata = 32'(i + 1);
            step();
        end
        bus.gld_we = 1'b0;
        run_to(50);
        write_dm(14'h3fff, 32'hffffffff, 4'hf);
        check("s1_first_req", bus.rd_req, 1);
        check("s1_first_addr", bus.rd_addr, 14'h2000);
        wait_done(done_at);
        check("s1_done_at", done_at, 56 + XR);
        check("s1_pass", bus.pass, 1);
        check("s1_err", bus.err_cnt, 0);
        check("s1_total", bus.total_cycle, 50);
        check("s1_timeout", bus.timeout, 0);
        check("s1_mm_cnt", mm_cnt, 0);
        check("s1_rd_cnt", rd_cnt, 4 + XR);
        check("s1_cyc_lo", bus.cyc_lo, (XR != 0) ? 32'h55 : 32'h0);
        check("s1_cyc_hi", bus.cyc_hi, (XR != 0) ? 32'h66 : 32'h0);
        step(); step(); step();
        check("s1_done_sticky", bus.done, 1);

        // scenario 2: word 0x2002 reads back 7
        dm_arr[2] = 32'd7;
        do_reset();
        run_to(20);
        write_dm(14'h3fff, 32'hffffffff, 4'hf);
        wait_done(done_at);
        check("s2_mm_cnt", mm_cnt, 1);
        check("s2_mm_addr", mm_a, 14'h2002);
        check("s2_mm_data", mm_d, 7);
        check("s2_mm_exp", mm_e, 3);
        check("s2_err", bus.err_cnt, 1);
        check("s2_pass", bus.pass, 0);
        dm_arr[2] = 32'd3;

        // scenario 3a: marker built from four byte writes (golden retained)
        do_reset();
        run_to(10);
        write_dm(14'h3fff, 32'h000000ff, 4'b0001);
        write_dm(14'h3fff, 32'h0000ff00, 4'b0010);
        write_dm(14'h3fff, 32'h00ff0000, 4'b0100);
        check("s3_no_trigger_3bytes", bus.rd_req, 0);
        write_dm(14'h3fff, 32'hff000000, 4'b1000);
        check("s3_trigger_4th", bus.rd_req, 1);
        wait_done(done_at);
        check("s3_total", bus.total_cycle, 13);
        check("s3_pass", bus.pass, 1);

        // scenario 3b + 4: partial marker does not trigger, then timeout
        do_reset();
        run_to(10);
        write_dm(14'h3fff, 32'hffff0000, 4'hf);
        run_to(30);
        check("s3b_rd_cnt", rd_cnt, 0);
        check("s3b_done", bus.done, 0);
        for (int k = 0; k < 200 && !bus.timeout; k++) step();
        check("s4_timeout", bus.timeout, 1);
        check("s4_timeout_at", cyc, 100);
        wait_done(done_at);
        check("s4_done_at", done_at, 105 + XR);
        check("s4_err", bus.err_cnt, 4);
        check("s4_pass", bus.pass, 0);
        check("s4_mm_cnt", mm_cnt, 0);

        // scenario 5: empty window
        bus.gld_num = 11'd0;
        do_reset();
        run_to(10);
        write_dm(14'h3fff, 32'hffffffff, 4'hf);
        wait_done(done_at);
        check("s5_done_at", done_at, 12 + XR);
        check("s5_rd_cnt", rd_cnt, XR);
        check("s5_pass", bus.pass, 1);
        check("s5_err", bus.err_cnt, 0);

        // scenario 6: N=2, words after the window hold the cycle count
        bus.gld_num = 11'd2;
        dm_arr[2] = 32'h1234; dm_arr[3] = 32'h0;
        do_reset();
        run_to(10);
        write_dm(14'h3fff, 32'hffffffff, 4'hf);
        wait_done(done_at);
        check("s6_done_at", done_at, 14 + XR);
        check("s6_cyc_lo", bus.cyc_lo, (XR != 0) ? 32'h1234 : 32'h0);
        check("s6_cyc_hi", bus.cyc_hi, 0);
        check("s6_pass", bus.pass, 1);
        dm_arr[2] = 32'd3; dm_arr[3] = 32'd4;

        // scenario 7: reset pulse mid-read returns to RUN; golden kept
        bus.gld_num = 11'd4;
        do_reset();
        run_to(10);
        write_dm(14'h3fff, 32'hffffffff, 4'hf);
        step();
        check("s7_in_read", bus.rd_req, 1);
        rst = 1'b1;
        #1;
        check("s7_rst_rd_req", bus.rd_req, 0);
        check("s7_rst_rd_addr", bus.rd_addr, 0);
        check("s7_rst_total", bus.total_cycle, 0);
        check("s7_rst_done", bus.done, 0);
        check("s7_rst_mm_valid", bus.mm_valid, 0);
        check("s7_rst_cyc_lo", bus.cyc_lo, 0);
        step();
        rst = 1'b0;
        cyc = 0; mm_cnt = 0; rd_cnt = 0;
        run_to(10);
        write_dm(14'h3fff, 32'hffffffff, 4'hf);
        wait_done(done_at);
        check("s7_done_at", done_at, 16 + XR);
        check("s7_pass", bus.pass, 1);
        check("s7_total", bus.total_cycle, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
